// File: rtl/video_timing_pattern_gen.sv
// Programmable raster timing generator with selectable test patterns.
// Emits a registered vde/hsync/vsync/RGB888 pixel stream, plus frame-start and busy flags.
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int BAR_W    = H_ACTIVE / 8
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_en,
    input  logic [1:0]  i_pattern,
    input  logic [23:0] i_solid_rgb,
    output logic        o_vid_vde,
    output logic        o_vid_hsync,
    output logic        o_vid_vsync,
    output logic [23:0] o_vid_data,
    output logic        o_frame_start,
    output logic        o_busy
);

    localparam logic [11:0] H_TOTAL     = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [11:0] V_TOTAL     = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [11:0] H_SYNC_W    = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_W    = 12'(V_SYNC);
    localparam logic [11:0] H_ACT_START = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_ACT_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [11:0] BAR_LAST    = 12'(BAR_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = 24'hFFFFFF;
            3'd1:    rgb = 24'hFFFF00;
            3'd2:    rgb = 24'h00FFFF;
            3'd3:    rgb = 24'h00FF00;
            3'd4:    rgb = 24'hFF00FF;
            3'd5:    rgb = 24'hFF0000;
            3'd6:    rgb = 24'h0000FF;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    state_t      state_q, state_d;
    logic [11:0] h_q, h_d, v_q, v_d;
    logic [1:0]  pat_q, pat_d;
    logic [23:0] solid_q, solid_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [11:0] bar_px_q, bar_px_d;
    logic        vde_q, vde_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic        fs_q, fs_d, busy_q, busy_d;
    logic [23:0] data_q, data_d;

    logic        run_s, frame_end_s, h_act_s, v_act_s, checker_s;
    logic [7:0]  gray_s;
    logic [23:0] pixel_s;

    // Next-state, counter, pattern latch and pixel computation.
    always_comb begin
        state_d   = state_q;
        h_d       = 12'd0;
        v_d       = 12'd0;
        pat_d     = pat_q;
        solid_d   = solid_q;
        bar_idx_d = 3'd0;
        bar_px_d  = 12'd0;
        pixel_s   = 24'h000000;

        run_s       = (state_q != ST_IDLE);
        frame_end_s = run_s && (h_q == H_TOTAL - 12'd1) && (v_q == V_TOTAL - 12'd1);
        h_act_s     = (h_q >= H_ACT_START) && (h_q < H_ACT_END);
        v_act_s     = (v_q >= V_ACT_START) && (v_q < V_ACT_END);
        gray_s      = 8'((h_q - H_ACT_START) >> 3);
        checker_s   = 1'(((h_q - H_ACT_START) ^ (v_q - V_ACT_START)) >> 6);

        // A stop request landing exactly on the last pixel needs no drain frame.
        case (state_q)
            ST_IDLE:  if (i_en) state_d = ST_RUN; else state_d = ST_IDLE;
            ST_RUN:   if (i_en) state_d = ST_RUN;
                      else if (frame_end_s) state_d = ST_IDLE;
                      else state_d = ST_DRAIN;
            ST_DRAIN: if (i_en) state_d = ST_RUN;
                      else if (frame_end_s) state_d = ST_IDLE;
                      else state_d = ST_DRAIN;
            default:  state_d = ST_IDLE;
        endcase

        if (run_s) begin
            if (h_q == H_TOTAL - 12'd1) begin
                h_d = 12'd0;
                v_d = (v_q == V_TOTAL - 12'd1) ? 12'd0 : v_q + 12'd1;
            end else begin
                h_d = h_q + 12'd1;
                v_d = v_q;
            end
        end else begin
            h_d = 12'd0;
            v_d = 12'd0;
        end

        if (run_s && (h_q == 12'd0) && (v_q == 12'd0)) begin
            pat_d   = i_pattern;
            solid_d = i_solid_rgb;
        end else begin
            pat_d   = pat_q;
            solid_d = solid_q;
        end

        // Bar counter restarts outside the active span so x=0 always begins at bar 0.
        if (h_act_s) begin
            if (bar_px_q == BAR_LAST) begin
                bar_px_d  = 12'd0;
                bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
            end else begin
                bar_px_d  = bar_px_q + 12'd1;
                bar_idx_d = bar_idx_q;
            end
        end else begin
            bar_px_d  = 12'd0;
            bar_idx_d = 3'd0;
        end

        case (pat_q)
            2'd0:    pixel_s = bar_colour(bar_idx_q);
            2'd1:    pixel_s = {gray_s, gray_s, gray_s};
            2'd2:    pixel_s = solid_q;
            2'd3:    pixel_s = checker_s ? 24'hFFFFFF : 24'h000000;
            default: pixel_s = 24'h000000;
        endcase

        vde_d   = run_s && h_act_s && v_act_s;
        data_d  = vde_d ? pixel_s : 24'h000000;
        hsync_d = !(run_s && (h_q < H_SYNC_W));
        vsync_d = !(run_s && (v_q < V_SYNC_W));
        fs_d    = run_s && (h_q == 12'd0) && (v_q == 12'd0);
        busy_d  = run_s;
    end

    // State, counters, latched pattern and output registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            h_q       <= 12'd0;
            v_q       <= 12'd0;
            pat_q     <= 2'd0;
            solid_q   <= 24'h000000;
            bar_idx_q <= 3'd0;
            bar_px_q  <= 12'd0;
            vde_q     <= 1'b0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            data_q    <= 24'h000000;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            pat_q     <= pat_d;
            solid_q   <= solid_d;
            bar_idx_q <= bar_idx_d;
            bar_px_q  <= bar_px_d;
            vde_q     <= vde_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            data_q    <= data_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
        end
    end

    assign o_vid_vde     = vde_q;
    assign o_vid_hsync   = hsync_q;
    assign o_vid_vsync   = vsync_q;
    assign o_vid_data    = data_q;
    assign o_frame_start = fs_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Scoreboard bench for video_timing_pattern_gen on a small raster (22 x 7 clocks per frame).
// A frame-position reference model queues expected outputs; a monitor pops and compares each cycle.
module tb_video_timing_pattern_gen;

    localparam int HA = 16, HFP = 2, HS = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1, BW = 2;
    localparam int HT = HS + HBP + HA + HFP;
    localparam int VT = VS + VBP + VA + VFP;
    localparam int FT = HT * VT;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    localparam logic [31:0] RESET_VEC = {3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [23:0] solid = 24'h0;
    logic        vde, hsync, vsync, fs, busy;
    logic [23:0] data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    bit          m_act = 1'b0;
    int          m_p = 0;
    int          m_pat = 0;
    logic [23:0] m_solid = 24'h0;

    always #5 clk = ~clk;

    video_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .BAR_W(BW)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_pattern(pattern), .i_solid_rgb(solid),
        .o_vid_vde(vde), .o_vid_hsync(hsync), .o_vid_vsync(vsync), .o_vid_data(data),
        .o_frame_start(fs), .o_busy(busy)
    );

    function automatic logic [31:0] out_vec();
        return {3'b000, vde, hsync, vsync, fs, busy, data};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: position within the frame, outputs derived from raster geometry.
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                exp_q.delete();
                m_act   = 1'b0;
                m_p     = 0;
                m_pat   = 0;
                m_solid = 24'h0;
            end else begin
                logic [31:0] e;
                logic [23:0] px;
                logic [7:0]  g;
                int h, v, x, y, idx;
                bit act;
                e = RESET_VEC;
                if (m_act) begin
                    if (m_p == 0) begin
                        m_pat   = int'(pattern);
                        m_solid = solid;
                    end
                    h = m_p % HT;
                    v = m_p / HT;
                    x = h - (HS + HBP);
                    y = v - (VS + VBP);
                    act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
                    case (m_pat)
                        0: begin
                            idx = x / BW;
                            if (idx > 7) idx = 7;
                            if (idx < 0) idx = 0;
                            px = BARS[idx];
                        end
                        1: begin
                            g  = 8'(x >> 3);
                            px = {g, g, g};
                        end
                        2: px = m_solid;
                        default: px = ((((x >> 6) ^ (y >> 6)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
                    endcase
                    e = {3'b000, act, (h >= HS), (v >= VS), (m_p == 0), 1'b1,
                         act ? px : 24'h000000};
                end
                exp_q.push_back(e);
                if (m_act) begin
                    if (m_p == FT - 1) begin
                        m_p   = 0;
                        m_act = en;
                    end else begin
                        m_p++;
                    end
                end else if (en) begin
                    m_act = 1'b1;
                    m_p   = 0;
                end
            end
        end
    end

    // Monitor: compares every output cycle and times back-to-back frame starts.
    initial begin
        int cyc = 0;
        int last_fs = 0;
        bit cont = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                check("reset_values", out_vec(), RESET_VEC);
            end else if (exp_q.size() > 0) begin
                check("stream", out_vec(), exp_q.pop_front());
            end
            if (!rstn || busy !== 1'b1) cont = 1'b0;
            if (rstn && fs === 1'b1) begin
                if (cont) check("frame_period", 32'(cyc - last_fs), 32'(FT));
                last_fs = cyc;
                cont    = 1'b1;
            end
        end
    end

    task automatic wait_fs();
        int i = 0;
        while (fs !== 1'b1 && i < 3 * FT) begin
            step();
            i++;
        end
        check("frame_start_seen", {31'b0, fs}, 32'd1);
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy !== 1'b0 && i < 3 * FT) begin
            step();
            i++;
        end
        check("drain_to_idle", {31'b0, busy}, 32'd0);
    endtask

    // Stimulus.
    initial begin
        repeat (5) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (500) step();

        pattern = 2'd0;
        en = 1'b1;
        repeat (2 * FT) step();
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 49) == 0) begin
                pattern = 2'($urandom);
                solid   = 24'($urandom);
            end
        end

        wait_fs();
        pattern = 2'd2;
        solid   = 24'h123456;
        repeat (3 * HT) step();
        en = 1'b0;
        wait_idle();
        repeat (20) step();

        pattern = 2'd1;
        en = 1'b1;
        repeat (2 * FT) step();

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(10, 120)) step();
            en = 1'b0;
            repeat ($urandom_range(1, 30)) step();
            en = 1'b1;
        end

        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 79) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) begin
                pattern = 2'($urandom);
                solid   = 24'($urandom);
            end
        end

        en = 1'b1;
        pattern = 2'd1;
        wait_fs();
        repeat (3 * HT) step();
        #2 rstn = 1'b0;
        #1 check("async_reset", out_vec(), RESET_VEC);
        repeat (3) step();
        rstn = 1'b1;
        repeat (2 * FT) step();
        en = 1'b0;
        wait_idle();
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
